// File: rtl/rede_taylor_pkg.sv
// rede_taylor_pkg: shared sizing constants and the tagged result word for the
// multicore output collector.
package rede_taylor_pkg;
    localparam int N_CORES    = 57;
    localparam int DATA_W     = 28;
    localparam int EN_W       = 4;
    localparam int IDX_W      = 6;
    localparam int FIFO_DEPTH = 8;
    localparam logic [EN_W-1:0] EN_VALID = 4'd1;

    typedef struct packed {
        logic [IDX_W-1:0]         idx;
        logic signed [DATA_W-1:0] data;
    } core_word_t;
endpackage

// File: rtl/collector_fifo.sv
// collector_fifo: synchronous show-ahead FIFO of core_word_t; a write is accepted
// while full when a pop happens in the same cycle.
module collector_fifo
    import rede_taylor_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_wr,
    input  logic       i_rd,
    input  core_word_t i_data,
    output core_word_t o_data,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);

    core_word_t  r_mem [DEPTH];
    logic [AW:0] r_wp, r_rp;
    logic        w_wr, w_rd;

    assign o_empty = r_wp == r_rp;
    assign o_full  = r_wp == {~r_rp[AW], r_rp[AW-1:0]};
    assign w_rd    = i_rd && !o_empty;
    assign w_wr    = i_wr && (!o_full || w_rd);
    // Head reads as zero when empty so the stream outputs are clean after reset.
    assign o_data  = o_empty ? '0 : r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/multicore_out_collector.sv
// multicore_out_collector: one hold slot per core, round-robin arbitration into a
// FIFO, and a tagged valid/ready result stream with overrun accounting.
module multicore_out_collector
    import rede_taylor_pkg::*;
#(
    parameter int N_CORES    = rede_taylor_pkg::N_CORES,
    parameter int DATA_W     = rede_taylor_pkg::DATA_W,
    parameter int EN_W       = rede_taylor_pkg::EN_W,
    parameter int FIFO_DEPTH = rede_taylor_pkg::FIFO_DEPTH,
    parameter int IDX_W      = rede_taylor_pkg::IDX_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [EN_W*N_CORES-1:0]   out_en_bus,
    input  logic [DATA_W*N_CORES-1:0] io_out_bus,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic signed [DATA_W-1:0]  m_data,
    output logic [IDX_W-1:0]          m_core,
    input  logic                      clr_ovf,
    output logic                      ovf,
    output logic [15:0]               drop_cnt
);
    logic [N_CORES-1:0]       r_pend, w_stb, w_clr, w_drop;
    logic signed [DATA_W-1:0] r_hold [N_CORES];
    logic [IDX_W-1:0]         r_rr, w_gnt;
    logic                     w_any, w_fire, w_full, w_empty, w_pop;
    logic [IDX_W:0]           w_ndrop;
    logic [16:0]              w_cnt_sum;
    core_word_t               w_wr_word, w_head;

    always_comb begin
        for (int i = 0; i < N_CORES; i++) w_stb[i] = out_en_bus[i*EN_W +: EN_W] == EN_VALID;
    end

    // Scan downward so the pending index closest to r_rr is the last to win.
    always_comb begin
        logic [IDX_W:0] w_j;
        w_any = 1'b0;
        w_gnt = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            w_j = {1'b0, r_rr} + (IDX_W+1)'(k);
            if (w_j >= (IDX_W+1)'(N_CORES)) w_j = w_j - (IDX_W+1)'(N_CORES);
            if (r_pend[IDX_W'(w_j)]) begin
                w_any = 1'b1;
                w_gnt = IDX_W'(w_j);
            end
        end
    end

    assign w_pop  = m_valid && m_ready;
    assign w_fire = w_any && (!w_full || w_pop);

    always_comb begin
        w_clr = '0;
        if (w_fire) w_clr[w_gnt] = 1'b1;
    end

    assign w_drop = w_stb & r_pend & ~w_clr;

    always_comb begin
        w_ndrop = '0;
        for (int i = 0; i < N_CORES; i++) w_ndrop += (IDX_W+1)'(w_drop[i]);
    end

    assign w_cnt_sum = {1'b0, clr_ovf ? 16'd0 : drop_cnt} + 17'(w_ndrop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend   <= '0;
            r_rr     <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            r_pend   <= (r_pend & ~w_clr) | w_stb;
            if (w_fire) r_rr <= (w_gnt == IDX_W'(N_CORES - 1)) ? '0 : w_gnt + 1'b1;
            ovf      <= (ovf && !clr_ovf) || |w_drop;
            drop_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
        end
    end

    // A slot freed by this cycle's grant may be refilled at the same edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CORES; i++)
            if (w_stb[i] && (!r_pend[i] || w_clr[i])) r_hold[i] <= io_out_bus[i*DATA_W +: DATA_W];
    end

    assign w_wr_word = '{idx: w_gnt, data: r_hold[w_gnt]};

    collector_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (w_fire),
        .i_rd    (w_pop),
        .i_data  (w_wr_word),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign m_valid = !w_empty;
    assign m_data  = w_head.data;
    assign m_core  = w_head.idx;
endmodule

// File: tb/tb_multicore_out_collector.sv
// tb_multicore_out_collector: scoreboard bench with a per-cycle behavioural model
// of hold slots, round-robin order and drop accounting.
module tb_multicore_out_collector;
    import rede_taylor_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, m_ready = 1'b0, clr_ovf = 1'b0;
    logic [EN_W*N_CORES-1:0]   en_bus = '0;
    logic [DATA_W*N_CORES-1:0] io_bus = '0;
    logic                      m_valid, ovf;
    logic signed [DATA_W-1:0]  m_data;
    logic [IDX_W-1:0]          m_core;
    logic [15:0]               drop_cnt;

    int n_chk = 0, n_pass = 0, n_pop = 0, base;
    longint last_c7 = 0;

    logic                     s_vld, s_ovf;
    logic signed [DATA_W-1:0] s_data;
    logic [IDX_W-1:0]         s_core;
    logic [15:0]              s_cnt;

    bit                        md_pend [N_CORES];
    logic [DATA_W-1:0]         md_hold [N_CORES];
    int                        md_rr, md_cnt, md_drops;
    bit                        md_ovf;
    logic [IDX_W+DATA_W-1:0]   exp_q [$];

    always #5 clk = ~clk;

    multicore_out_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .out_en_bus (en_bus),
        .io_out_bus (io_bus),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_core     (m_core),
        .clr_ovf    (clr_ovf),
        .ovf        (ovf),
        .drop_cnt   (drop_cnt)
    );

    function automatic void chk(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N_CORES; i++) md_pend[i] = 0;
        md_rr = 0; md_cnt = 0; md_drops = 0; md_ovf = 0;
        exp_q.delete();
    endfunction

    always @(negedge clk) begin
        s_vld = m_valid; s_data = m_data; s_core = m_core; s_ovf = ovf; s_cnt = drop_cnt;
    end

    always @(posedge clk) if (rst_n) begin : mdl
        logic [IDX_W+DATA_W-1:0] w;
        bit pop;
        int g, nd;
        chk("m_valid", s_vld, md_cnt > 0);
        chk("ovf", s_ovf, md_ovf);
        chk("drop_cnt", s_cnt, md_drops);
        if (s_vld && m_ready) begin
            if (exp_q.size() == 0) chk("stream_underflow", 1, 0);
            else begin
                w = exp_q.pop_front();
                chk("m_core", s_core, w[DATA_W +: IDX_W]);
                chk("m_data", s_data, $signed(w[DATA_W-1:0]));
                if (s_core == 7) last_c7 = s_data;
                n_pop++;
            end
        end
        pop = md_cnt > 0 && m_ready;
        g = -1;
        if (md_cnt < FIFO_DEPTH || pop)
            for (int k = 0; k < N_CORES && g < 0; k++)
                if (md_pend[(md_rr + k) % N_CORES]) g = (md_rr + k) % N_CORES;
        if (g >= 0) begin
            exp_q.push_back({IDX_W'(g), md_hold[g]});
            md_pend[g] = 0;
            md_rr = (g + 1) % N_CORES;
            md_cnt++;
        end
        if (pop) md_cnt--;
        if (clr_ovf) begin md_ovf = 0; md_drops = 0; end
        nd = 0;
        for (int i = 0; i < N_CORES; i++)
            if (en_bus[i*EN_W +: EN_W] == 4'd1) begin
                if (md_pend[i]) nd++;
                else begin md_pend[i] = 1; md_hold[i] = io_bus[i*DATA_W +: DATA_W]; end
            end
        md_drops = (md_drops + nd > 65535) ? 65535 : md_drops + nd;
        if (nd > 0) md_ovf = 1;
    end

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(negedge clk);
            en_bus = '0;
            clr_ovf = 1'b0;
            for (int c = 0; c < N_CORES; c++) io_bus[c*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
    endtask

    task automatic strobe(int c, logic [EN_W-1:0] v, logic [DATA_W-1:0] d);
        en_bus[c*EN_W +: EN_W] = v;
        io_bus[c*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        cyc(2);
        chk("reset_valid", m_valid, 0);
        chk("reset_data", m_data, 0);
        chk("reset_core", m_core, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_cnt", drop_cnt, 0);
        rst_n = 1'b1;

        m_ready = 1'b1;
        strobe(5, EN_VALID, -1234);
        cyc();
        chk("single_e0_valid", m_valid, 0);
        cyc();
        chk("single_valid", m_valid, 1);
        chk("single_core", m_core, 5);
        chk("single_data", $signed(m_data), -1234);
        cyc();
        chk("single_once", m_valid, 0);

        do_reset();
        m_ready = 1'b1;
        strobe(0, EN_VALID, 10); strobe(3, EN_VALID, 20); strobe(56, EN_VALID, 30);
        cyc(2);
        chk("sim_core0", m_core, 0);
        chk("sim_data0", $signed(m_data), 10);
        cyc();
        chk("sim_core3", m_core, 3);
        chk("sim_data3", $signed(m_data), 20);
        cyc();
        chk("sim_core56", m_core, 56);
        chk("sim_data56", $signed(m_data), 30);
        cyc();
        chk("sim_done", m_valid, 0);
        strobe(0, EN_VALID, 11); strobe(3, EN_VALID, 21); strobe(56, EN_VALID, 31);
        cyc(2);
        chk("sim_wrap_core", m_core, 0);
        cyc(4);

        m_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            strobe(10 + k, EN_VALID, DATA_W'($urandom));
            cyc();
        end
        cyc(3);
        chk("bp_valid", m_valid, 1);
        chk("bp_head_core", m_core, 10);
        chk("bp_ovf", ovf, 0);
        chk("bp_drop", drop_cnt, 0);
        base = n_pop;
        m_ready = 1'b1;
        cyc(20);
        chk("bp_delivered", n_pop - base, 12);

        m_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            strobe(20 + k, EN_VALID, DATA_W'($urandom));
            cyc();
        end
        cyc(2);
        strobe(7, EN_VALID, 100);
        cyc();
        strobe(7, EN_VALID, 200);
        cyc(2);
        chk("ovr_ovf", ovf, 1);
        chk("ovr_cnt", drop_cnt, 1);
        clr_ovf = 1'b1;
        cyc();
        chk("clr_ovf", ovf, 0);
        chk("clr_cnt", drop_cnt, 0);
        m_ready = 1'b1;
        cyc(12);
        chk("ovr_keep_first", last_c7, 100);

        strobe(2, 4'd0, 1); strobe(9, 4'd2, 2); strobe(40, 4'd15, 3);
        cyc(4);
        chk("nonvalid_idle", m_valid, 0);

        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            strobe(30 + k, EN_VALID, DATA_W'($urandom));
            cyc();
        end
        cyc(2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_data", m_data, 0);
        chk("rst_mid_core", m_core, 0);
        model_reset();
        cyc();
        rst_n = 1'b1;
        m_ready = 1'b1;
        strobe(1, EN_VALID, 777);
        cyc();
        chk("rst_after_e0", m_valid, 0);
        cyc();
        chk("rst_after_valid", m_valid, 1);
        chk("rst_after_core", m_core, 1);
        chk("rst_after_data", $signed(m_data), 777);
        cyc(3);

        for (int t = 0; t < 400; t++) begin
            m_ready = ($urandom_range(3) != 0);
            clr_ovf = ($urandom_range(31) == 0);
            for (int c = 0; c < N_CORES; c++)
                if ($urandom_range(15) == 0)
                    strobe(c, ($urandom_range(9) < 7) ? EN_VALID : EN_W'($urandom), DATA_W'($urandom));
            cyc();
        end
        m_ready = 1'b1;
        cyc(80);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_valid", m_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/multicore_out_collector.md
# multicore_out_collector

Sink-side counterpart of the core output interface. Captures the per-core `io_out`/`out_en` results of the `multicore` array and serializes them into a single valid/ready stream tagged with the originating core index. Sits between `multicore` and the downstream result consumer, replacing bench-level file dumping in hardware builds. Holds one pending result per core, arbitrates round-robin into a small FIFO, and counts results lost to overrun.

## Interface

Parameters:
- `N_CORES`, 57: number of core output ports.
- `DATA_W`, 28: signed result width.
- `EN_W`, 4: width of each `out_en` field.
- `FIFO_DEPTH`, 8: output FIFO entries (power of two, ≥2).
- `IDX_W`, 6: core index width, must satisfy 2^IDX_W ≥ N_CORES.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `out_en_bus`  in  EN_W*N_CORES  core i strobe in slice i; a field equal to 4'd1 means result valid, any other value means idle.
- `io_out_bus`  in  DATA_W*N_CORES  core i signed result in slice i.
- `m_valid`  out  1  stream word available.
- `m_ready`  in  1  consumer accepts word.
- `m_data`  out  DATA_W  signed result.
- `m_core`  out  IDX_W  originating core index.
- `clr_ovf`  in  1  synchronous clear of `ovf` and `drop_cnt`.
- `ovf`  out  1  sticky: at least one result dropped.
- `drop_cnt`  out  16  saturating count of dropped results.

## Operation

- Per core i: hold register `hold_data[i]` and flag `pend[i]`.
- Capture: at an edge where field i == 4'd1:
  - If `pend[i]`=0, or it is cleared by a grant at the same edge, load `hold_data[i]` and set `pend[i]`.
  - Otherwise drop the new value, keep the old one, set `ovf`, and increment `drop_cnt` (saturate at 16'hFFFF).
  - Multiple cores dropping at one edge add their count, saturating.
- Arbitration: combinational round-robin over `pend`, starting at index `rr_ptr`.
  - When the FIFO is not full and any `pend` is set, grant one index g, write {g, hold_data[g]} into the FIFO, clear `pend[g]`, and set `rr_ptr` = g+1 (wrapping N_CORES-1→0).
  - At most one grant per cycle.
  - FIFO full: no grant; pending values wait.
- FIFO: show-ahead. `m_valid` = not empty; `m_data`/`m_core` = head entry. Pop on `m_valid && m_ready`.
  - Write and pop in the same cycle while full is permitted: the occupancy stays at FIFO_DEPTH and the write is accepted.
- `clr_ovf`: clears `ovf` and `drop_cnt` at the next edge. If a drop occurs at the same edge, the result is `ovf`=1 and `drop_cnt`=number of drops at that edge.
- Reset (any time, including mid-transfer):
  - all `pend`=0, `rr_ptr`=0, FIFO empty;
  - `m_valid`=0, `m_data`=0, `m_core`=0;
  - `ovf`=0, `drop_cnt`=0.
  - In-flight results are discarded.

## Timing

- Latency from `out_en` sampled at edge E0 to `m_valid`: `pend` is set at E0, the grant is written to the FIFO at E1, and `m_valid` is high after E1. This gives 2 cycles with an idle FIFO.
- Sustained throughput: 1 word/cycle when `m_ready`=1.
- Data, index and `m_valid` stay stable while `m_valid && !m_ready`.
- All outputs are registered or driven from FIFO storage. There is no combinational path from `out_en_bus`/`io_out_bus` to stream outputs.

## Structure

- Shared package `rede_taylor_pkg`:
  - constants `N_CORES`, `DATA_W`, `EN_W`, `IDX_W`;
  - `EN_VALID` = 4'd1;
  - typedef `core_word_t` = {IDX_W index, signed DATA_W data}.
- Sub-module `collector_fifo`: synchronous show-ahead FIFO of `core_word_t`, with full/empty flags and pointers one bit wider than log2(FIFO_DEPTH).
- Arbiter and hold array are in the top level.

## Test plan

- Single result: core 5 strobes with -1234, `m_ready`=1 → 2 cycles later `m_valid`=1, `m_core`=5, `m_data`=-1234, then `m_valid`=0.
- Simultaneous: cores 0, 3 and 56 strobe in one cycle with 10, 20, 30 → words appear on consecutive cycles in order core 0, 3, 56. The next burst starts after 56 and wraps to 0.
- Backpressure: hold `m_ready`=0 and issue 12 single strobes from distinct cores → 8 words in the FIFO, 4 remain pending, no drops. Release `m_ready` → all 12 words emerge intact, each appearing once.
- Overrun: with `m_ready`=0 and the FIFO full, core 7 strobes 100 then 200 → `ovf`=1, `drop_cnt`=1, and 100 is delivered later. Pulse `clr_ovf` → `ovf`=0, `drop_cnt`=0.
- Non-valid enables: field values 4'd0, 4'd2 and 4'd15 → nothing is captured.
- Reset mid-stream: assert `rst_n`=0 asynchronously with 5 words queued → `m_valid` drops immediately and all outputs read 0. After release, a new strobe from core 1 is delivered with 2-cycle latency.
